line_delay_ctrl: RTL and testbench
==================================

Name: line_delay_ctrl

Overview:
- Control stage wrapped around the 24-bit line FIFO in the image pipeline.
- Writes every active input pixel into the FIFO and reads the previous line back out in lock-step with the current line.
- Output is a paired stream of current pixel and the pixel directly above it, used by downstream vertical filters (e.g. 2-row gradient or averaging).
- Drives the FIFO's din/wr_en/rd_en and consumes its dout/empty/wr_rst_busy.

Parameters:
- WIDTH, 24, pixel width in bits (RGB888); must match the FIFO.
- IMG_W, 240, active pixels per line; legal range 1..255.
- DEPTH, 256, FIFO depth; the occupancy limit is DEPTH-1.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_vs  in  1  one-cycle frame-start pulse, asserted during vertical blanking
- pix_de  in  1  active-pixel strobe; high for IMG_W consecutive cycles per line
- pix_data  in  WIDTH  input pixel
- fifo_din  out  WIDTH  FIFO write data
- fifo_wr_en  out  1  FIFO write enable
- fifo_rd_en  out  1  FIFO read enable
- fifo_dout  in  WIDTH  FIFO read data (valid 1 cycle after rd_en)
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_rst_busy  in  1  FIFO reset-busy flag
- cur_de  out  1  output pixel valid
- cur_data  out  WIDTH  current-line pixel
- prev_data  out  WIDTH  pixel from the previous line, same column
- prev_valid  out  1  prev_data meaningful (line index ≥ 1)
- err_len  out  1  sticky: a line length differed from IMG_W
- err_ovf  out  1  sticky: a write was dropped at occupancy DEPTH-1 or during FLUSH

Behaviour:
- Reset: every output and internal register is 0; state = IDLE.
- States:
  - IDLE → FIRST when fifo_wr_rst_busy = 0.
  - FIRST: the first line of a frame. Writes only; no reads.
  - STEADY: writes and reads on every pix_de.
  - FLUSH: drains stale FIFO data.
- Transitions:
  - FIRST → STEADY on the falling edge of pix_de (end of the first line).
  - pix_vs in FIRST or STEADY → FLUSH.
  - FLUSH: fifo_rd_en = ~fifo_empty each cycle; output is discarded. FLUSH → FIRST when fifo_empty = 1 and no read is outstanding.
- Writes: fifo_wr_en = pix_de (combinational), fifo_din = pix_data, in FIRST and STEADY only.
  - pix_de during IDLE is ignored.
  - pix_de during FLUSH: write dropped, err_ovf set.
- Reads: fifo_rd_en = pix_de in STEADY.
- Alignment: cur_de and cur_data are pix_de and pix_data registered once, so they align with fifo_dout (1-cycle FIFO latency).
  - prev_data = fifo_dout when prev_valid, else 0.
  - prev_valid = registered (pix_de & STEADY).
  - Total latency: 1 cycle input to output.
- Occupancy counter (9 bits):
  - +1 on write only, -1 on read only, unchanged when both occur in the same cycle.
  - A write with occupancy = DEPTH-1 and no read is suppressed (fifo_wr_en forced 0) and sets err_ovf.
  - A read is never issued when occupancy = 0, even in STEADY.
- Column counter: counts pix_de within a line and clears on the pix_de falling edge. If the count at the falling edge ≠ IMG_W, err_len is set; state transitions still occur.
- Sticky errors clear only on rst.
- pix_vs coinciding with pix_de: vs wins, the current pixel is dropped, err_ovf is set.
- rst mid-line: immediate return to IDLE. The FIFO is reset by the same rst, so no flush is needed.

Test Plan:
1. IMG_W=4, frame of 3 lines with data 0x000001..0x00000C → line 0: prev_valid=0. Line 1: cur_data 0x05..0x08 paired with prev_data 0x01..0x04. Line 2: 0x09..0x0C paired with 0x05..0x08. Output lags input by exactly 1 cycle.
2. After scenario 1, pix_vs then a new line 0x10..0x13 starting 8 cycles later → FLUSH issues 4 reads, state reaches FIRST, new line has prev_valid=0, and stale 0x09..0x0C never appears on prev_data.
3. Line of 3 pixels with IMG_W=4 → err_len=1 and stays 1 through following correct lines until rst.
4. pix_de held high with IMG_W=255 and reads inhibited (single-line, FIRST) → occupancy saturates at 255, write 256 suppressed, err_ovf=1, fifo_wr_en=0 on that cycle.
5. Assert rst mid-line in STEADY → next cycle all outputs 0 and state IDLE. After release, the first line has prev_valid=0.
6. pix_vs coincident with pix_de → pixel dropped, err_ovf=1, FLUSH entered.

Source files
------------

// File: rtl/line_delay_ctrl.sv
// Line-delay control around a 24-bit line FIFO: writes each active pixel, reads the
// previous line back in lock-step, and emits {current, above} pixel pairs.
module line_delay_ctrl #(
    parameter int WIDTH = 24,
    parameter int IMG_W = 240,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_vs,
    input  logic             pix_de,
    input  logic [WIDTH-1:0] pix_data,
    output logic [WIDTH-1:0] fifo_din,
    output logic             fifo_wr_en,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_wr_rst_busy,
    output logic             cur_de,
    output logic [WIDTH-1:0] cur_data,
    output logic [WIDTH-1:0] prev_data,
    output logic             prev_valid,
    output logic             err_len,
    output logic             err_ovf
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_STEADY = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam logic [8:0] OCC_MAX  = 9'(DEPTH - 1);
    localparam logic [8:0] LINE_LEN = 9'(IMG_W);

    logic [1:0]       state_q, state_d;
    logic [8:0]       occ_q, occ_d;
    logic [8:0]       col_q, col_d;
    logic             de_q, de_d;
    logic             rd_pend_q, rd_pend_d;
    logic             cur_de_q, cur_de_d;
    logic [WIDTH-1:0] cur_data_q, cur_data_d;
    logic             prev_valid_q, prev_valid_d;
    logic             err_len_q, err_len_d;
    logic             err_ovf_q, err_ovf_d;

    logic active, accept, fall;
    logic wr_en, rd_en;

    // A frame-start pulse always wins over a coincident pixel.
    assign active = (state_q == ST_FIRST) || (state_q == ST_STEADY);
    assign accept = active && pix_de && !pix_vs;
    assign fall   = de_q && !pix_de;

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        col_d        = col_q;
        de_d         = pix_de;
        rd_pend_d    = 1'b0;
        err_len_d    = err_len_q;
        err_ovf_d    = err_ovf_q;
        rd_en        = 1'b0;
        wr_en        = 1'b0;

        if (state_q == ST_STEADY && accept && occ_q != 9'd0)
            rd_en = 1'b1;
        if (state_q == ST_FLUSH)
            rd_en = !fifo_empty;

        if (accept) begin
            if (occ_q == OCC_MAX && !rd_en)
                err_ovf_d = 1'b1;
            else
                wr_en = 1'b1;
        end
        if (pix_de && !accept && (state_q == ST_FLUSH || (active && pix_vs)))
            err_ovf_d = 1'b1;

        if (wr_en && !rd_en)
            occ_d = occ_q + 9'd1;
        else if (!wr_en && rd_en && occ_q != 9'd0)
            occ_d = occ_q - 9'd1;

        if (accept)
            col_d = col_q + 9'd1;
        if (fall) begin
            col_d = 9'd0;
            if (active && col_q != LINE_LEN)
                err_len_d = 1'b1;
        end

        rd_pend_d    = rd_en && (state_q == ST_FLUSH);
        cur_de_d     = accept;
        cur_data_d   = accept ? pix_data : '0;
        prev_valid_d = rd_en && (state_q == ST_STEADY);

        case (state_q)
            ST_IDLE:   if (!fifo_wr_rst_busy) state_d = ST_FIRST;
            ST_FIRST:  begin
                if (pix_vs)    state_d = ST_FLUSH;
                else if (fall) state_d = ST_STEADY;
            end
            ST_STEADY: if (pix_vs) state_d = ST_FLUSH;
            default: begin
                // Leave only once the FIFO is empty and the last read has landed.
                if (fifo_empty && !rd_pend_q) begin
                    state_d = ST_FIRST;
                    occ_d   = 9'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            occ_q        <= 9'd0;
            col_q        <= 9'd0;
            de_q         <= 1'b0;
            rd_pend_q    <= 1'b0;
            cur_de_q     <= 1'b0;
            cur_data_q   <= '0;
            prev_valid_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            col_q        <= col_d;
            de_q         <= de_d;
            rd_pend_q    <= rd_pend_d;
            cur_de_q     <= cur_de_d;
            cur_data_q   <= cur_data_d;
            prev_valid_q <= prev_valid_d;
            err_len_q    <= err_len_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    assign fifo_din   = pix_data;
    assign fifo_wr_en = wr_en;
    assign fifo_rd_en = rd_en;
    assign cur_de     = cur_de_q;
    assign cur_data   = cur_data_q;
    assign prev_valid = prev_valid_q;
    assign prev_data  = prev_valid_q ? fifo_dout : '0;
    assign err_len    = err_len_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Bench for line_delay_ctrl: behavioural line FIFO, a table of per-cycle vectors for
// the normal frame/flush flow, and hand sequences for the multi-cycle corner cases.
module tb_line_delay_ctrl;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pix_vs = 1'b0;
    logic         pix_de = 1'b0;
    logic [W-1:0] pix_data = '0;
    logic [W-1:0] fifo_din, fifo_dout;
    logic         fifo_wr_en, fifo_rd_en, fifo_empty, fifo_wr_rst_busy;
    logic         cur_de, prev_valid, err_len, err_ovf;
    logic [W-1:0] cur_data, prev_data;

    logic [W-1:0] b_din, b_cur_data, b_prev_data;
    logic         b_wr_en, b_rd_en, b_cur_de, b_prev_valid, b_err_len, b_err_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    line_delay_ctrl #(.WIDTH(W), .IMG_W(4), .DEPTH(256)) u_dut (
        .clk(clk), .rst(rst), .pix_vs(pix_vs), .pix_de(pix_de), .pix_data(pix_data),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_wr_rst_busy(fifo_wr_rst_busy),
        .cur_de(cur_de), .cur_data(cur_data), .prev_data(prev_data), .prev_valid(prev_valid),
        .err_len(err_len), .err_ovf(err_ovf)
    );

    // Full-width line variant, only used for the occupancy saturation case.
    line_delay_ctrl #(.WIDTH(W), .IMG_W(255), .DEPTH(256)) u_big (
        .clk(clk), .rst(rst), .pix_vs(pix_vs), .pix_de(pix_de), .pix_data(pix_data),
        .fifo_din(b_din), .fifo_wr_en(b_wr_en), .fifo_rd_en(b_rd_en),
        .fifo_dout('0), .fifo_empty(1'b1), .fifo_wr_rst_busy(fifo_wr_rst_busy),
        .cur_de(b_cur_de), .cur_data(b_cur_data), .prev_data(b_prev_data), .prev_valid(b_prev_valid),
        .err_len(b_err_len), .err_ovf(b_err_ovf)
    );

    // Behavioural FIFO: 1-cycle read latency, registered empty flag, reset-busy tail.
    logic [W-1:0] fq[$];
    logic [2:0]   busy_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            logic [W-1:0] tmp;
            if (fifo_rd_en && fq.size() > 0) begin
                tmp = fq.pop_front();
                fifo_dout <= tmp;
            end
            if (fifo_wr_en) fq.push_back(fifo_din);
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 3'd4;
        else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
    end
    assign fifo_wr_rst_busy = (busy_cnt != 3'd0);

    typedef struct {
        logic         vs;
        logic         de;
        logic [W-1:0] d;
        logic         wr;
        logic         rd;
        logic         cde;
        logic [W-1:0] cdata;
        logic         pv;
        logic [W-1:0] pdata;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic vs, input logic de, input logic [W-1:0] d,
                                input logic wr, input logic rd, input logic cde,
                                input logic [W-1:0] cdata, input logic pv, input logic [W-1:0] pdata);
        vec_t v;
        v.vs = vs; v.de = de; v.d = d; v.wr = wr; v.rd = rd;
        v.cde = cde; v.cdata = cdata; v.pv = pv; v.pdata = pdata;
        tbl.push_back(v);
    endfunction

    function automatic void add_line(input logic [W-1:0] base, input logic first);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] cur;
            cur = base + W'(i);
            add(1'b0, 1'b1, cur, 1'b1, !first, 1'b1, cur, !first, first ? '0 : cur - W'(4));
        end
    endfunction

    function automatic void add_idle(input int n, input logic rd);
        for (int i = 0; i < n; i++)
            add(1'b0, 1'b0, '0, 1'b0, rd, 1'b0, '0, 1'b0, '0);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
        end
    endtask

    task automatic apply(input logic vs, input logic de, input logic [W-1:0] d);
        pix_vs = vs; pix_de = de; pix_data = d;
        #1;
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk1();
            if (!fifo_wr_rst_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("ready_within_bound", ok, 1'b1);
        clk1();
    endtask

    task automatic do_reset();
        apply(1'b0, 1'b0, '0);
        rst = 1'b1;
        clk1();
        clk1();
        rst = 1'b0;
        wait_ready();
    endtask

    task automatic plain_line(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b1, base + W'(i));
            clk1();
        end
        apply(1'b0, 1'b0, '0);
        clk1();
        clk1();
    endtask

    initial begin
        int nrd;

        // Frame of three lines, then vs, flush and a fresh first line.
        add_line(24'h000001, 1'b1); add_idle(2, 1'b0);
        add_line(24'h000005, 1'b0); add_idle(2, 1'b0);
        add_line(24'h000009, 1'b0); add_idle(2, 1'b0);
        add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        add_idle(4, 1'b1);
        add_idle(3, 1'b0);
        add_line(24'h000010, 1'b1); add_idle(2, 1'b0);

        // Reset state while rst is held.
        #2;
        chk1("rst cur_de", cur_de, 1'b0);
        chkd("rst cur_data", cur_data, '0);
        chk1("rst prev_valid", prev_valid, 1'b0);
        chkd("rst prev_data", prev_data, '0);
        chk1("rst err_len", err_len, 1'b0);
        chk1("rst err_ovf", err_ovf, 1'b0);
        chk1("rst wr_en", fifo_wr_en, 1'b0);
        chk1("rst rd_en", fifo_rd_en, 1'b0);
        rst = 1'b0;
        wait_ready();

        foreach (tbl[i]) begin
            apply(tbl[i].vs, tbl[i].de, tbl[i].d);
            chk1($sformatf("row%0d wr_en", i), fifo_wr_en, tbl[i].wr);
            chk1($sformatf("row%0d rd_en", i), fifo_rd_en, tbl[i].rd);
            clk1();
            chk1($sformatf("row%0d cur_de", i), cur_de, tbl[i].cde);
            if (tbl[i].cde)
                chkd($sformatf("row%0d cur_data", i), cur_data, tbl[i].cdata);
            chk1($sformatf("row%0d prev_valid", i), prev_valid, tbl[i].pv);
            chkd($sformatf("row%0d prev_data", i), prev_data, tbl[i].pdata);
            $display("row %0d vs=%0b de=%0b d=%06h -> cur=%0b/%06h prev=%0b/%06h",
                     i, tbl[i].vs, tbl[i].de, tbl[i].d, cur_de, cur_data, prev_valid, prev_data);
        end
        chk1("frame err_len", err_len, 1'b0);
        chk1("frame err_ovf", err_ovf, 1'b0);

        // Short line sets a sticky length error.
        do_reset();
        plain_line(24'h000100, 3);
        chk1("short err_len", err_len, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 24'h000200 + W'(i));
            chk1("after_short rd_en", fifo_rd_en, 1'b1);
            clk1();
        end
        apply(1'b0, 1'b0, '0); clk1(); clk1();
        chk1("sticky err_len 1", err_len, 1'b1);
        plain_line(24'h000300, 4);
        chk1("sticky err_len 2", err_len, 1'b1);
        chk1("short err_ovf", err_ovf, 1'b0);
        $display("short-line sequence done err_len=%0b", err_len);

        // Occupancy saturation in FIRST.
        do_reset();
        chk1("sat cleared err_len", err_len, 1'b0);
        for (int i = 1; i <= 256; i++) begin
            apply(1'b0, 1'b1, W'(i));
            if (i == 1 || i == 255) begin
                chk1($sformatf("sat wr_en %0d", i), fifo_wr_en, 1'b1);
                chk1($sformatf("sat big wr_en %0d", i), b_wr_en, 1'b1);
            end
            if (i == 256) begin
                chk1("sat wr_en 256", fifo_wr_en, 1'b0);
                chk1("sat big wr_en 256", b_wr_en, 1'b0);
                chk1("sat rd_en 256", fifo_rd_en, 1'b0);
            end
            clk1();
            if (i == 255) begin
                chk1("sat err_ovf before", err_ovf, 1'b0);
                chk1("sat big err_ovf before", b_err_ovf, 1'b0);
            end
        end
        chk1("sat err_ovf", err_ovf, 1'b1);
        chk1("sat big err_ovf", b_err_ovf, 1'b1);
        apply(1'b0, 1'b0, '0); clk1();
        $display("saturation sequence done err_ovf=%0b", err_ovf);

        // Reset in the middle of a STEADY line.
        do_reset();
        plain_line(24'h000400, 4);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 24'h000500 + W'(i));
            clk1();
        end
        chk1("mid prev_valid before rst", prev_valid, 1'b1);
        apply(1'b0, 1'b1, 24'h000502);
        rst = 1'b1;
        #1;
        chk1("mid rst cur_de", cur_de, 1'b0);
        chkd("mid rst cur_data", cur_data, '0);
        chk1("mid rst prev_valid", prev_valid, 1'b0);
        chkd("mid rst prev_data", prev_data, '0);
        chk1("mid rst wr_en", fifo_wr_en, 1'b0);
        chk1("mid rst rd_en", fifo_rd_en, 1'b0);
        clk1();
        rst = 1'b0;
        apply(1'b0, 1'b0, '0);
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 24'h000600 + W'(i));
            chk1("post_rst wr_en", fifo_wr_en, 1'b1);
            chk1("post_rst rd_en", fifo_rd_en, 1'b0);
            clk1();
            chk1("post_rst cur_de", cur_de, 1'b1);
            chk1("post_rst prev_valid", prev_valid, 1'b0);
        end
        apply(1'b0, 1'b0, '0); clk1();
        $display("mid-line reset sequence done");

        // vs coincident with de: pixel dropped, overflow flag, flush, new FIRST line.
        do_reset();
        plain_line(24'h000700, 4);
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 24'h000800 + W'(i));
            clk1();
        end
        apply(1'b1, 1'b1, 24'h0000AA);
        chk1("vsde wr_en", fifo_wr_en, 1'b0);
        chk1("vsde rd_en", fifo_rd_en, 1'b0);
        clk1();
        chk1("vsde cur_de", cur_de, 1'b0);
        chk1("vsde err_ovf", err_ovf, 1'b1);
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, '0);
            if (fifo_rd_en) nrd++;
            clk1();
            chk1("vsde flush prev_valid", prev_valid, 1'b0);
        end
        chkd("vsde flush reads", W'(nrd), W'(4));
        apply(1'b0, 1'b1, 24'h000900);
        chk1("vsde new wr_en", fifo_wr_en, 1'b1);
        chk1("vsde new rd_en", fifo_rd_en, 1'b0);
        clk1();
        chk1("vsde new cur_de", cur_de, 1'b1);
        chkd("vsde new cur_data", cur_data, 24'h000900);
        chk1("vsde new prev_valid", prev_valid, 1'b0);
        apply(1'b0, 1'b0, '0); clk1();
        $display("vs/de collision sequence done flush_reads=%0d", nrd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
